uart_tx_fifo: RTL

Byte-wide transmit FIFO plus UART serializer that consumes the byte stream issued by the SD UART controller (`sd_tx_en` / `sd_tx_data`) and drives the host-facing serial TX line. It decouples the controller's single-cycle byte pushes, such as a burst of 16 CID bytes, from the much slower 8N1 line rate. Output format is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.

---
 rtl/uart_tx_fifo.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO feeding an 8N1 UART serializer for the SD controller TX stream.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_en,
  input  logic [7:0]            tx_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int c_DEPTH  = 1 << DEPTH_LOG2;
  localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [c_BAUD_W-1:0]   c_BAUD_LAST  = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0]   c_FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  logic [7:0]            r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;
  logic [1:0]            r_state;
  logic [c_BAUD_W-1:0]   r_baud;
  logic [2:0]            r_bit_idx;
  logic [7:0]            r_shift;
  logic                  r_tx;

  logic                  w_baud_done;
  logic                  w_has_data;
  logic                  w_wr;
  logic                  w_pop;
  logic [1:0]            w_state_next;
  logic [7:0]            w_shift_next;
  logic                  w_tx_next;
  logic [DEPTH_LOG2:0]   w_count_next;

  assign w_baud_done = (r_baud == c_BAUD_LAST);
  assign w_has_data  = (r_count != '0);
  // Writes are judged against the pre-edge full flag, so a same-cycle pop never frees room.
  assign w_wr        = tx_en && !r_full;

  // ---------------------------------------------------------------- FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------- FSM next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (w_has_data) w_state_next = c_START;
      c_START: if (w_baud_done) w_state_next = c_DATA;
      c_DATA:  if (w_baud_done && (r_bit_idx == 3'd7)) w_state_next = c_STOP;
      c_STOP:  if (w_baud_done) w_state_next = w_has_data ? c_START : c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM outputs
  always_comb begin
    w_pop        = 1'b0;
    w_shift_next = r_shift;
    w_tx_next    = 1'b1;
    if ((r_state == c_IDLE) || ((r_state == c_STOP) && w_baud_done)) begin
      w_pop = w_has_data;
    end
    if (w_pop) begin
      w_shift_next = r_mem[r_rd_ptr];
    end else if ((r_state == c_DATA) && w_baud_done) begin
      w_shift_next = {1'b0, r_shift[7:1]};
    end
    // Line value follows the state being entered so tx changes exactly on bit boundaries.
    case (w_state_next)
      c_START: w_tx_next = 1'b0;
      c_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_next;
      r_full     <= (w_count_next == c_FULL_COUNT);
      r_empty    <= (w_count_next == '0);
      r_overflow <= tx_en && r_full;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
    end else begin
      if (w_pop || (r_state == c_IDLE) || w_baud_done) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + 1'b1;
      end
      if ((r_state == c_START) && w_baud_done) begin
        r_bit_idx <= 3'd0;
      end else if ((r_state == c_DATA) && w_baud_done) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  assign tx       = r_tx;
  assign busy     = (r_state != c_IDLE);
  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule
`default_nettype wire
